// File: rtl/lift_pkg.sv
// Shared types for the SCAN lift controller: FSM state encoding and the
// direction codes driven on dir_o.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    // Direction shown while in a given state; DOOR keeps whatever came before.
    function automatic logic [1:0] dir_of(state_t s, logic [1:0] held);
        unique case (s)
            MOVE_UP:   dir_of = DIR_UP;
            MOVE_DOWN: dir_of = DIR_DN;
            DOOR:      dir_of = held;
            default:   dir_of = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lift_scan_ctrl_if.sv
// Request/status bundle between the button logic (master) and the lift
// controller (slave).
interface lift_scan_ctrl_if #(
    parameter int N_FLOORS = 8
);
    localparam int FW = $clog2(N_FLOORS);

    logic                call_vld_i;
    logic [FW-1:0]       call_f_i;
    logic                car_vld_i;
    logic [FW-1:0]       car_f_i;
    logic [FW-1:0]       elev_f_o;
    logic                busy_o;
    logic [1:0]          dir_o;
    logic                door_open_o;
    logic [N_FLOORS-1:0] pend_o;

    modport master (
        output call_vld_i, call_f_i, car_vld_i, car_f_i,
        input  elev_f_o, busy_o, dir_o, door_open_o, pend_o
    );

    modport slave (
        input  call_vld_i, call_f_i, car_vld_i, car_f_i,
        output elev_f_o, busy_o, dir_o, door_open_o, pend_o
    );

endinterface

// File: rtl/lift_req_reg.sv
// Pending-request mask with set/clear ports and hit/above/below lookup
// relative to a query floor.
module lift_req_reg #(
    parameter int N_FLOORS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_FLOORS-1:0]           set_mask,
    input  logic [N_FLOORS-1:0]           clr_mask,
    input  logic [$clog2(N_FLOORS)-1:0]   qry_f,
    output logic [N_FLOORS-1:0]           pend,
    output logic                          hit_here,
    output logic                          any_above,
    output logic                          any_below
);

    // NOTE: rst_n is active-high here; clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) pend <= '0;
        else       pend <= (pend | set_mask) & ~clr_mask;
    end

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        hit_here  = 1'b0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i == int'(qry_f)) hit_here = pend[i];
            if (i >  int'(qry_f)) any_above = any_above | pend[i];
            if (i <  int'(qry_f)) any_below = any_below | pend[i];
        end
    end

endmodule

// File: rtl/lift_scan_ctrl.sv
// Single-car SCAN lift controller with per-floor travel and door dwell timing.
// Optional parking toward HOME_FLOOR after a long idle: define LIFT_PARK_EN.
module lift_scan_ctrl
    import lift_pkg::*;
#(
    parameter int N_FLOORS   = 8,
    parameter int T_MOVE     = 4,
    parameter int T_DOOR     = 6,
    parameter int HOME_FLOOR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    lift_scan_ctrl_if.slave  bus
);

    localparam int FW = $clog2(N_FLOORS);
    localparam int MW = (T_MOVE > 1) ? $clog2(T_MOVE) : 1;
    localparam int DW = (T_DOOR > 1) ? $clog2(T_DOOR) : 1;
    localparam logic [MW-1:0] MOVE_LAST = MW'(T_MOVE - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(T_DOOR - 1);

    if (N_FLOORS < 2 || T_MOVE < 1 || T_DOOR < 1 ||
        HOME_FLOOR < 0 || HOME_FLOOR >= N_FLOORS) begin : g_param_chk
        $error("lift_scan_ctrl: illegal parameter set");
    end

    state_t              state, state_nxt;
    logic [FW-1:0]       elev_f, qry_f;
    logic [MW-1:0]       move_cnt;
    logic [DW-1:0]       door_cnt;
    logic [1:0]          dir_q, dir_nxt;
    logic                door_q, busy;
    logic [N_FLOORS-1:0] pend, set_mask, clr_mask;
    logic                hit_here, any_above, any_below;
    logic                moving, step, retrig, door_done, decide, pref_dn;

`ifdef LIFT_PARK_EN
    localparam int IW = $clog2(16 * T_DOOR);
    localparam logic [IW-1:0] IDLE_LAST = IW'(16 * T_DOOR - 1);
    localparam logic [FW-1:0] HOME_F    = FW'(HOME_FLOOR);

    logic [IW-1:0] idle_cnt;
    logic          idle_arm, park_due, park_q;

    assign idle_arm = (state == IDLE) && (pend == '0) && (elev_f != HOME_F);
    assign park_due = idle_arm && (idle_cnt == IDLE_LAST);

    // park_q marks a homing trip; it drops once the car stops (DOOR or IDLE).
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            idle_cnt <= '0;
            park_q   <= 1'b0;
        end else begin
            idle_cnt <= (idle_arm && !park_due) ? idle_cnt + 1'b1 : '0;
            park_q   <= ((state_nxt == MOVE_UP) || (state_nxt == MOVE_DOWN)) &&
                        (park_q || park_due);
        end
    end
`endif

    lift_req_reg #(.N_FLOORS(N_FLOORS)) u_req (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_mask  (set_mask),
        .clr_mask  (clr_mask),
        .qry_f     (qry_f),
        .pend      (pend),
        .hit_here  (hit_here),
        .any_above (any_above),
        .any_below (any_below)
    );

    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign step      = moving && (move_cnt == MOVE_LAST);
    assign retrig    = (state == DOOR) &&
                       ((bus.call_vld_i && (bus.call_f_i == elev_f)) ||
                        (bus.car_vld_i  && (bus.car_f_i  == elev_f)));
    assign door_done = (state == DOOR) && (door_cnt == '0) && !retrig;

    // On an arrival edge the mask is queried at the floor being entered.
    assign qry_f = !step             ? elev_f :
                   (state == MOVE_UP) ? elev_f + 1'b1 : elev_f - 1'b1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        pref_dn   = 1'b0;
        unique case (state)
            IDLE:              decide = 1'b1;
            MOVE_UP, MOVE_DOWN: begin
                decide  = step;
                pref_dn = (state == MOVE_DOWN);
            end
            DOOR: begin
                decide  = door_done;
                pref_dn = (dir_q == DIR_DN);
            end
            default:           decide = 1'b0;
        endcase

        if (decide) begin
            if (hit_here)
                state_nxt = DOOR;
            else if (any_above && !(pref_dn && any_below))
                state_nxt = MOVE_UP;
            else if (any_below)
                state_nxt = MOVE_DOWN;
`ifdef LIFT_PARK_EN
            else if (park_due || (park_q && (qry_f != HOME_F)))
                state_nxt = (HOME_F > qry_f) ? MOVE_UP : MOVE_DOWN;
`endif
            else
                state_nxt = IDLE;
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        dir_nxt  = dir_of(state_nxt, dir_q);
        clr_mask = '0;
        set_mask = '0;
        if (state_nxt == DOOR) clr_mask[qry_f] = 1'b1;
        // A request for the floor whose door is open only extends the dwell.
        if (bus.call_vld_i && (int'(bus.call_f_i) < N_FLOORS) &&
            !((state == DOOR) && (bus.call_f_i == elev_f)))
            set_mask[bus.call_f_i] = 1'b1;
        if (bus.car_vld_i && (int'(bus.car_f_i) < N_FLOORS) &&
            !((state == DOOR) && (bus.car_f_i == elev_f)))
            set_mask[bus.car_f_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            elev_f   <= '0;
            move_cnt <= '0;
            door_cnt <= '0;
            dir_q    <= DIR_NONE;
            door_q   <= 1'b0;
        end else begin
            if (step) elev_f <= qry_f;
            move_cnt <= (moving && !step) ? move_cnt + 1'b1 : '0;
            if ((state_nxt == DOOR) && ((state != DOOR) || retrig || (door_cnt == '0)))
                door_cnt <= DOOR_LAST;
            else if (state_nxt == DOOR)
                door_cnt <= door_cnt - 1'b1;
            else
                door_cnt <= '0;
            dir_q    <= dir_nxt;
            door_q   <= (state_nxt == DOOR);
        end
    end

    assign bus.elev_f_o    = elev_f;
    assign bus.busy_o      = busy;
    assign bus.dir_o       = dir_q;
    assign bus.door_open_o = door_q;
    assign bus.pend_o      = pend;

endmodule
